// File: rtl/tdm_demux_using_counter_if.sv
// Bus bundle for the TDM receive demux: upstream word stream in,
// per-channel held words and status out.
// Optional parity signals are present only when TDM_DEMUX_PARITY_EN is defined.
interface tdm_demux_using_counter_if #(
   parameter int N_CH = 4,
   parameter int W    = 8
);
   logic                up_valid;
   logic                up_sof;
   logic [W-1:0]        up_data;
   logic [N_CH*W-1:0]   down_data;
   logic [N_CH-1:0]     down_valid;
   logic                locked;
   logic                frame_err;
   logic [15:0]         frame_cnt;
`ifdef TDM_DEMUX_PARITY_EN
   logic                up_parity;
   logic                parity_err;
`endif

   modport master (
      output up_valid, up_sof, up_data,
`ifdef TDM_DEMUX_PARITY_EN
      output up_parity,
      input  parity_err,
`endif
      input  down_data, down_valid, locked, frame_err, frame_cnt
   );

   modport slave (
      input  up_valid, up_sof, up_data,
`ifdef TDM_DEMUX_PARITY_EN
      input  up_parity,
      output parity_err,
`endif
      output down_data, down_valid, locked, frame_err, frame_cnt
   );
endinterface

// File: rtl/tdm_demux_using_counter.sv
// TDM receive demux: locks to the frame marked by up_sof, steers each word
// to its channel's held register and pulses that channel's valid.
// Optional even-parity checking on each beat: define TDM_DEMUX_PARITY_EN.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_HUNT   | not framed; non-SOF beats dropped, SOF beat locks as ch 0
//   S_LOCKED | framed; ptr names the channel the next beat belongs to
module tdm_demux_using_counter #(
   parameter int N_CH = 4,
   parameter int W    = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   tdm_demux_using_counter_if.slave  bus
);
   localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [PW-1:0] PTR_LAST = PW'(N_CH - 1);
   // With one channel the pointer never leaves 0.
   localparam logic [PW-1:0] PTR_ONE  = (N_CH > 1) ? PW'(1) : '0;

   typedef enum logic {S_HUNT, S_LOCKED} state_t;

   state_t            state, state_nxt;
   logic [PW-1:0]     ptr, ptr_nxt;
   logic              slot_hit;
   logic [PW-1:0]     slot_ch;
   logic              err_nxt;
   logic              beat_bad;
   logic              deliver;

   logic [N_CH*W-1:0] data_q;
   logic [N_CH-1:0]   valid_q;
   logic              err_q;
   logic [15:0]       cnt_q;

`ifdef TDM_DEMUX_PARITY_EN
   logic              perr_q;
   assign beat_bad = ^{bus.up_data, bus.up_parity};
`else
   assign beat_bad = 1'b0;
`endif

   // A slot that fails parity still advances framing but is not written.
   assign deliver = slot_hit & ~beat_bad;

   // Next-state decode: slot selection, pointer advance and framing errors.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      slot_hit  = 1'b0;
      slot_ch   = '0;
      err_nxt   = 1'b0;
      if (bus.up_valid) begin
         case (state)
            S_HUNT: begin
               if (bus.up_sof) begin
                  slot_hit  = 1'b1;
                  ptr_nxt   = PTR_ONE;
                  state_nxt = S_LOCKED;
               end
            end
            S_LOCKED: begin
               if (bus.up_sof) begin
                  // Early SOF resyncs onto channel 0 but is still flagged.
                  err_nxt  = (ptr != '0);
                  slot_hit = 1'b1;
                  ptr_nxt  = PTR_ONE;
               end else if (ptr != '0) begin
                  slot_hit = 1'b1;
                  slot_ch  = ptr;
                  ptr_nxt  = (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
               end else begin
                  err_nxt   = 1'b1;
                  ptr_nxt   = '0;
                  state_nxt = S_HUNT;
               end
            end
            default: begin
               state_nxt = S_HUNT;
               ptr_nxt   = '0;
            end
         endcase
      end
   end

   // State, pointer and registered outputs; pulses clear every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_HUNT;
         ptr     <= '0;
         data_q  <= '0;
         valid_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
`ifdef TDM_DEMUX_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         ptr     <= ptr_nxt;
         valid_q <= '0;
         err_q   <= err_nxt;
`ifdef TDM_DEMUX_PARITY_EN
         perr_q  <= slot_hit & beat_bad;
`endif
         for (int k = 0; k < N_CH; k++) begin
            if (deliver && slot_ch == PW'(k)) begin
               data_q[k*W +: W] <= bus.up_data;
               valid_q[k]       <= 1'b1;
            end
         end
         if (slot_hit && slot_ch == PTR_LAST)
            cnt_q <= cnt_q + 16'd1;
      end
   end

   assign bus.down_data  = data_q;
   assign bus.down_valid = valid_q;
   assign bus.locked     = (state == S_LOCKED);
   assign bus.frame_err  = err_q;
   assign bus.frame_cnt  = cnt_q;
`ifdef TDM_DEMUX_PARITY_EN
   assign bus.parity_err = perr_q;
`endif
endmodule

// File: tb/tb_tdm_demux_using_counter.sv
// Bench for the TDM receive demux: a frame-level reference model predicts
// every output cycle; a monitor compares the DUT against the queued
// predictions one cycle after each stimulus cycle.
module tb_tdm_demux_using_counter;
   localparam int N_CH = 4;
   localparam int W    = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tdm_demux_using_counter_if #(.N_CH(N_CH), .W(W)) bus ();

   tdm_demux_using_counter #(.N_CH(N_CH), .W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [N_CH*W-1:0] data;
      logic [N_CH-1:0]   valid;
      logic              locked;
      logic              err;
      logic              perr;
      logic [15:0]       cnt;
   } exp_t;

   exp_t q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // Reference model: frame lock flag, expected slot, held words, frame count.
   bit           m_locked;
   int           m_slot;
   logic [W-1:0] m_ch [N_CH];
   int           m_cnt;

   task automatic apply(input bit r, input bit v, input bit s,
                        input logic [W-1:0] d, input bit p);
      exp_t e;
      bit   bad;
      int   ch;
      @(negedge clk);
      rst          = r;
      bus.up_valid = v;
      bus.up_sof   = s;
      bus.up_data  = d;
`ifdef TDM_DEMUX_PARITY_EN
      bus.up_parity = p;
      bad = ((^d) ^ p) != 1'b0;
`else
      bad = p & 1'b0;
`endif
      e.valid = '0;
      e.err   = 1'b0;
      e.perr  = 1'b0;
      ch      = -1;
      if (r) begin
         m_locked = 1'b0;
         m_slot   = 0;
         m_cnt    = 0;
         for (int k = 0; k < N_CH; k++) m_ch[k] = '0;
      end else if (v) begin
         if (s) begin
            if (m_locked && m_slot != 0) e.err = 1'b1;
            ch       = 0;
            m_slot   = 1 % N_CH;
            m_locked = 1'b1;
         end else if (m_locked && m_slot != 0) begin
            ch     = m_slot;
            m_slot = (m_slot + 1) % N_CH;
         end else if (m_locked) begin
            e.err    = 1'b1;
            m_locked = 1'b0;
            m_slot   = 0;
         end
         if (ch >= 0) begin
            if (bad) e.perr = 1'b1;
            else begin
               m_ch[ch]    = d;
               e.valid[ch] = 1'b1;
            end
            if (ch == N_CH - 1) m_cnt = (m_cnt + 1) % 65536;
         end
      end
      e.locked = m_locked;
      e.cnt    = m_cnt[15:0];
      for (int k = 0; k < N_CH; k++) e.data[k*W +: W] = m_ch[k];
      q.push_back(e);
   endtask

   // Monitor: one registered output cycle per queued prediction.
   exp_t mon_e;
   bit   mon_bad;
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         mon_e   = q.pop_front();
         vectors = vectors + 1;
         mon_bad = (bus.down_data !== mon_e.data) || (bus.down_valid !== mon_e.valid) ||
                   (bus.locked !== mon_e.locked) || (bus.frame_err !== mon_e.err) ||
                   (bus.frame_cnt !== mon_e.cnt);
`ifdef TDM_DEMUX_PARITY_EN
         if (bus.parity_err !== mon_e.perr) mon_bad = 1'b1;
`endif
         if (mon_bad) begin
            miscompares = miscompares + 1;
            $display("FAIL vec%0d outputs: got data=%h valid=%b locked=%b err=%b cnt=%0d, want data=%h valid=%b locked=%b err=%b cnt=%0d",
                     vectors, bus.down_data, bus.down_valid, bus.locked, bus.frame_err, bus.frame_cnt,
                     mon_e.data, mon_e.valid, mon_e.locked, mon_e.err, mon_e.cnt);
         end
      end
   end

   int           gslot;
   bit           rr, rv, rs, rp;
   logic [W-1:0] rd;

   initial begin
      rst          = 1'b1;
      bus.up_valid = 1'b0;
      bus.up_sof   = 1'b0;
      bus.up_data  = '0;
`ifdef TDM_DEMUX_PARITY_EN
      bus.up_parity = 1'b0;
`endif
      apply(1, 0, 0, 8'h00, 0);
      apply(1, 0, 0, 8'h00, 0);

      // Clean frame from reset.
      apply(0, 1, 1, 8'hA0, ^8'hA0);
      apply(0, 1, 0, 8'hA1, ^8'hA1);
      apply(0, 1, 0, 8'hA2, ^8'hA2);
      apply(0, 1, 0, 8'hA3, ^8'hA3);
      apply(0, 0, 0, 8'h00, 0);

      // HUNT drops non-SOF beats, then locks on SOF.
      apply(1, 0, 0, 8'h00, 0);
      apply(0, 1, 0, 8'h11, ^8'h11);
      apply(0, 1, 0, 8'h22, ^8'h22);
      apply(0, 1, 1, 8'h33, ^8'h33);

      // Early SOF at ptr=2 resyncs to channel 0.
      apply(0, 1, 0, 8'h44, ^8'h44);
      apply(0, 1, 1, 8'h55, ^8'h55);
      apply(0, 1, 0, 8'h66, ^8'h66);
      apply(0, 1, 0, 8'h67, ^8'h67);
      apply(0, 1, 0, 8'h68, ^8'h68);

      // Missing SOF at ptr=0 drops to HUNT, then relock.
      apply(0, 1, 0, 8'h77, ^8'h77);
      apply(0, 0, 0, 8'h00, 0);
      apply(0, 1, 1, 8'h78, ^8'h78);
      apply(0, 1, 0, 8'h79, ^8'h79);
      apply(0, 1, 0, 8'h7A, ^8'h7A);
      apply(0, 1, 0, 8'h7B, ^8'h7B);

      // Gapped frame, then reset mid-frame.
      apply(1, 0, 0, 8'h00, 0);
      for (int b = 0; b < N_CH; b++) begin
         rd = 8'hA0 + 8'(b);
         apply(0, 1, b == 0, rd, ^rd);
         for (int g = 0; g < 3; g++) apply(0, 0, 0, 8'hFF, 0);
      end
      apply(0, 1, 1, 8'hB0, ^8'hB0);
      apply(0, 1, 0, 8'hB1, ^8'hB1);
      apply(1, 0, 0, 8'h00, 0);
      apply(0, 0, 0, 8'h00, 0);

`ifdef TDM_DEMUX_PARITY_EN
      // Bad parity on channel 1 is skipped without disturbing framing.
      apply(0, 1, 1, 8'h01, ^8'h01);
      apply(0, 1, 0, 8'h03, 1'b1);
      apply(0, 1, 0, 8'h04, ^8'h04);
      apply(0, 1, 0, 8'h05, ^8'h05);
`endif

      // Mostly well-framed random traffic with occasional framing faults,
      // parity faults, idles and resets.
      gslot = 0;
      for (int i = 0; i < 800; i++) begin
         rr = ($urandom_range(0, 199) == 0);
         rv = ($urandom_range(0, 3) != 0);
         rs = (gslot == 0) ^ ($urandom_range(0, 15) == 0);
         rd = W'($urandom);
         rp = (^rd) ^ ($urandom_range(0, 9) == 0);
         apply(rr, rv, rs, rd, rp);
         if (rr) gslot = 0;
         else if (rv) gslot = (gslot + 1) % N_CH;
      end

      apply(0, 0, 0, 8'h00, 0);
      repeat (3) @(posedge clk);
      #2;
      if (q.size() != 0) begin
         miscompares = miscompares + 1;
         $display("FAIL drain: %0d predictions left, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/tdm_demux_using_counter.md
Name: tdm_demux_using_counter

Overview:
- Receive end of a time-division multiplexed link.
- A single upstream word stream carries N_CH channels in fixed round-robin slots; the start of each frame is marked by up_sof on the channel-0 word.
- The block locks to the frame, steers each word to its channel's output register, and pulses that channel's valid.
- Sits after the link receiver; feeds the per-channel consumers.

Parameters:
- N_CH, 4, number of TDM channels per frame (>=1).
- W, 8, data width of one channel word.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- up_valid  input  1  upstream word present this cycle
- up_sof  input  1  start of frame; qualified by up_valid; marks the channel-0 word
- up_data  input  W  upstream word
- down_data  output  N_CH*W  per-channel held words; channel k occupies bits [k*W +: W]
- down_valid  output  N_CH  one-cycle pulse per channel when its slice is updated
- locked  output  1  high while in LOCKED state
- frame_err  output  1  one-cycle pulse on a framing violation
- frame_cnt  output  16  count of completed frames; wraps 0xFFFF -> 0

Behaviour:
- Reset (rst=1 at a clk edge):
  - down_data=0, down_valid=0, locked=0, frame_err=0, frame_cnt=0.
  - Slot pointer ptr=0; state=HUNT.
  - Reset mid-frame discards any partial frame.
- Beats and timing:
  - A beat is a cycle with up_valid=1. Cycles with up_valid=0 change nothing except clearing the pulses.
  - All outputs are registered. A beat in cycle t appears on down_data/down_valid/frame_err in cycle t+1.
  - down_valid and frame_err are high for exactly one cycle per event.
- State HUNT:
  - Beat with up_sof=1: word goes to channel 0; ptr <- 1 mod N_CH; state -> LOCKED.
  - Beat with up_sof=0: dropped, no pulse, no error.
- State LOCKED, beat with ptr==0 and up_sof=1: normal channel-0 word; ptr <- 1 mod N_CH.
- State LOCKED, beat with ptr!=0 and up_sof=0: word goes to channel ptr; ptr <- (ptr+1) mod N_CH.
- State LOCKED, beat with ptr!=0 and up_sof=1 (early SOF):
  - frame_err pulses.
  - Beat is taken as channel 0 (resync); ptr <- 1 mod N_CH.
  - Stays LOCKED; frame_cnt is not incremented.
- State LOCKED, beat with ptr==0 and up_sof=0 (missing SOF):
  - frame_err pulses; beat dropped.
  - ptr <- 0; state -> HUNT.
- frame_cnt increments when channel N_CH-1 is delivered.
- Delivering a word to channel k updates only slice k and pulses only down_valid[k]. Other slices hold their values.
- N_CH=1: ptr is constant 0, so every beat must carry up_sof. Each beat delivers to channel 0 and increments frame_cnt.
- ptr uses $clog2(N_CH) bits, minimum 1. Wrap-around at N_CH-1 is explicit, not power-of-two truncation.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- When defined:
  - Adds input up_parity (1 bit) and output parity_err (1 bit, reset 0).
  - On a beat, if ^up_data ^ up_parity != 0 (even parity), the word is not written and down_valid is not pulsed.
  - parity_err pulses one cycle, same timing as down_valid.
  - ptr, state and frame_cnt advance exactly as for a good beat, so framing is unaffected.
- When not defined: no up_parity/parity_err ports and no checking.

Test Plan:
1. Reset, then N_CH=4 beats 0xA0(sof),0xA1,0xA2,0xA3 on consecutive cycles -> locked=1 one cycle after the first beat; down_valid pulses 0001,0010,0100,1000 on successive cycles; down_data=0xA3A2A1A0; frame_cnt=1.
2. In HUNT, beats 0x11,0x22 without sof, then 0x33(sof) -> first two dropped, no frame_err; channel 0 = 0x33; locked=1.
3. While locked at ptr=2, beat 0x55 with sof -> frame_err pulse; channel 0 = 0x55; next beat 0x66 lands on channel 1; frame_cnt unchanged.
4. Locked at ptr=0, beat 0x77 without sof -> frame_err pulse; locked=0; down_data unchanged; next sof beat relocks.
5. Frame with up_valid gaps of 3 idle cycles between beats -> same final down_data as scenario 1; no pulses during idle cycles. Then assert rst mid-frame -> all outputs 0, locked=0.
6. (TDM_DEMUX_PARITY_EN) Beat 0x03 with up_parity=1 on channel 1 -> parity_err pulse; down_valid[1]=0; slice 1 unchanged; next beat goes to channel 2.
